// File: rtl/mult_pkg.sv
// Shared constants for the sequential multiplier and the controller/datapath that drive it.
package mult_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_RUN    = 2'd1;
    localparam state_t ST_FINISH = 2'd2;

    localparam int DEFAULT_WIDTH = 32;

    // Guarded so a 1-bit configuration still gets a usable counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

    localparam logic [5:0] OPC_MULT   = 6'h1c;
    localparam logic [2:0] ALUOP_MULT = 3'b101;

endpackage

// File: rtl/mult_unit.sv
// Iterative shift-add multiplier: one partial product per cycle on operand magnitudes,
// with the sign applied once to the full 2*WIDTH product at the end.
module mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CW = cnt_width(WIDTH);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic               neg;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;

    // The most negative value negates to itself, which read as unsigned is its true magnitude.
    assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

    // Carry-out is kept as bit WIDTH so the right shift never loses it.
    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);

    assign busy = (state == ST_RUN) || (state == ST_FINISH);

    // NOTE: all state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, and reset is sampled on the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc    <= {sum, acc[WIDTH-1:1]};
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    {hi, lo} <= neg ? -acc : acc;
                    done     <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_unit.sv
// Directed-vector bench for mult_unit: result values, latency, busy window,
// ignored restarts and mid-operation reset.
module tb_mult_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         is_signed;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] lo;
    logic [W-1:0] hi;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mult_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .lo        (lo),
        .hi        (hi)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // inj: 0 = none, 1 = start 9x9 while busy, 2 = reset mid-RUN, 3 = start during FINISH
    task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input int inj, input logic exp_done,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int           done_k   = -1;
        int           done_cnt = 0;
        int           busy_cnt = 0;
        logic [W-1:0] lo_prev  = lo;
        logic [W-1:0] hi_prev  = hi;

        is_signed = sgn;
        a         = av;
        b         = bv;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        if (busy) busy_cnt++;
        for (int k = 1; k <= 45; k++) begin
            if (inj == 1 && k == 10) begin
                start = 1'b1;
                a     = 9;
                b     = 9;
            end
            if (inj == 2 && k == 15) rst_n = 1'b0;
            if (inj == 3 && k == 33) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            rst_n = 1'b1;
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (busy) busy_cnt++;
            if (k == 5) begin
                check({tag, " lo held in RUN"}, lo, lo_prev);
                check({tag, " hi held in RUN"}, hi, hi_prev);
            end
        end
        if (exp_done) begin
            check({tag, " done latency"}, done_k, 33);
            check({tag, " done pulses"}, done_cnt, 1);
            check({tag, " busy cycles"}, busy_cnt, 33);
            check({tag, " hi"}, hi, ehi);
            check({tag, " lo"}, lo, elo);
        end else begin
            check({tag, " no done"}, done_cnt, 0);
            check({tag, " busy cleared"}, busy, 1'b0);
            check({tag, " hi cleared"}, hi, 0);
            check({tag, " lo cleared"}, lo, 0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("u 7x6",        1'b0, 32'd7,        32'd6,        0, 1'b1, 32'h0000_0000, 32'h0000_002A);
        run_op("s -3x5",       1'b1, 32'hFFFF_FFFD, 32'd5,        0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("u max x max",  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("s min x -1",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 32'h0000_0000, 32'h8000_0000);
        run_op("s 7x-6",       1'b1, 32'd7,        32'hFFFF_FFFA, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFD6);
        run_op("u min x 2",    1'b0, 32'h8000_0000, 32'd2,        0, 1'b1, 32'h0000_0001, 32'h0000_0000);
        run_op("busy restart", 1'b0, 32'd2,        32'd3,        1, 1'b1, 32'h0000_0000, 32'h0000_0006);
        run_op("finish start", 1'b0, 32'd5,        32'd5,        3, 1'b1, 32'h0000_0000, 32'h0000_0019);
        run_op("reset abort",  1'b0, 32'd4,        32'd4,        2, 1'b0, 32'h0000_0000, 32'h0000_0000);
        run_op("after reset",  1'b0, 32'd4,        32'd4,        0, 1'b1, 32'h0000_0000, 32'h0000_0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have port start, input, 1, multiply request pulse from the main controller's MULT state.
REQ-005 SHALL have port is_signed, input, 1, 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have port a, input, WIDTH, multiplicand from register A; sampled with start.
REQ-007 SHALL have port b, input, WIDTH, multiplier from register B; sampled with start.
REQ-008 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking that the result is valid.
REQ-010 SHALL have port lo, output, WIDTH, low half of the product; this is what is written back to rd.
REQ-011 SHALL have port hi, output, WIDTH, high half of the product.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and FINISH.
- IDLE -> RUN on start.
- RUN -> FINISH after WIDTH iterations.
- FINISH -> IDLE unconditionally.
REQ-013 On start in IDLE, SHALL latch the operand magnitudes (abs value when is_signed=1) and the result sign (a_msb XOR b_msb, when is_signed=1).
REQ-014 SHALL clear the 2*WIDTH accumulator and the iteration counter on start in IDLE.
REQ-015 In RUN, SHALL perform one shift-add step per cycle.
- If the multiplier LSB is 1, add the multiplicand into the upper half of the accumulator.
- Then shift right by 1, keeping the carry-out bit.
- The counter increments each step.
REQ-016 SHALL leave RUN when the counter reaches WIDTH-1 with that step completed; exactly WIDTH RUN cycles.
REQ-017 In FINISH, SHALL register {hi,lo} as the accumulator, two's-complement negated over 2*WIDTH bits if the latched result sign is 1; done=1 for this cycle only.
REQ-018 Latency: start sampled high at edge N SHALL give done=1 during the cycle after edge N+WIDTH+1 (33 cycles for WIDTH=32).
REQ-019 busy SHALL be 1 in RUN and FINISH and 0 in IDLE; busy rises the cycle after start is accepted.
REQ-020 start while busy=1 SHALL be ignored; operands SHALL not be resampled and latency SHALL be unaffected.
REQ-021 start in the FINISH cycle SHALL be ignored; a new operation is accepted only from IDLE.
REQ-022 hi and lo SHALL hold their last result until the next FINISH; they SHALL not change during RUN.
REQ-023 Signed edge case: the most negative operand SHALL be handled using a WIDTH+1-bit-free magnitude (abs(0x80000000) = 0x80000000 unsigned) with no overflow error.
REQ-024 Operand changes on a and b after acceptance SHALL not affect the result.

Reset
REQ-025 While rst_n=0 at a clock edge, SHALL force:
- state = IDLE;
- busy = 0, done = 0, hi = 0, lo = 0;
- counter and accumulator = 0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst_n=1 SHALL run normally.

Structure
REQ-027 A shared package mult_pkg SHALL hold the state encoding typedef, default WIDTH, and the counter width constant ($clog2(WIDTH)).
REQ-028 The MULT opcode (6'h1c) and the controller's MULT ALUOp code (3'b101) SHALL be exported from mult_pkg so that the controller and the datapath share them.
REQ-029 No sub-module SHALL be used; the FSM and the shift-add datapath SHALL reside in mult_unit.

Verification
REQ-030 Unsigned 7 x 6 -> lo=0x0000002A, hi=0x00000000; done exactly 33 cycles after start; busy high for 33 cycles.
REQ-031 Signed -3 (0xFFFFFFFD) x 5 -> lo=0xFFFFFFF1, hi=0xFFFFFFFF.
REQ-032 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 Signed 0x80000000 x 0xFFFFFFFF -> hi=0x00000000, lo=0x80000000.
REQ-034 Start 2 x 3, then pulse start with 9 x 9 at cycle 10 -> single done at cycle 33 with lo=6; second start ignored.
REQ-035 Reset at cycle 15 of 4 x 4 -> no done, hi=lo=0; then 4 x 4 -> lo=16 after 33 cycles.
